// File: rtl/load_scoreboard_pkg.sv
// rtl/load_scoreboard_pkg.sv - shared register-index types and constants for the load scoreboard
package load_scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  // x0 is hardwired, so it is never tracked as a pending destination or source
  function automatic logic is_tracked(input reg_idx_t r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/load_scoreboard_if.sv
// rtl/load_scoreboard_if.sv - issue/decode/memory-response bundle of the load scoreboard
interface load_scoreboard_if #(
  parameter int DEPTH = 4
);
  import load_scoreboard_pkg::*;

  logic                   issue_valid;
  logic                   issue_is_load;
  reg_idx_t               issue_rd;
  reg_idx_t               rs1;
  reg_idx_t               rs2;
  logic                   mem_rvalid;
  logic                   issue_stall;
  logic                   hazard_stall;
  logic                   wb_valid;
  reg_idx_t               wb_rd;
  logic [$clog2(DEPTH):0] pending_count;
  logic [NUM_REGS-1:0]    busy;
  logic                   err_unexpected;

  // pipeline side drives issue, decode sources and memory responses
  modport master (
    output issue_valid, issue_is_load, issue_rd, rs1, rs2, mem_rvalid,
    input  issue_stall, hazard_stall, wb_valid, wb_rd, pending_count, busy, err_unexpected
  );

  // scoreboard side
  modport slave (
    input  issue_valid, issue_is_load, issue_rd, rs1, rs2, mem_rvalid,
    output issue_stall, hazard_stall, wb_valid, wb_rd, pending_count, busy, err_unexpected
  );

endinterface

// File: rtl/load_rd_fifo.sv
// rtl/load_rd_fifo.sv - in-order queue of pending load destinations
module load_rd_fifo
  import load_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  reg_idx_t               push_rd,
  input  logic                   pop,
  output reg_idx_t               head_rd,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  reg_idx_t         mem_q [DEPTH];
  reg_idx_t         mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign head_rd = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // next pointer and storage values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_rd;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // pointer and storage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= REG_ZERO;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - busy-bit scoreboard for in-flight loads with load-use interlock
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  load_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0]    busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   load_req;
  logic                   stall;
  logic                   push;
  logic                   pop;
  reg_idx_t               head_rd;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  load_rd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_rd (sb.issue_rd),
    .pop     (pop),
    .head_rd (head_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // issue acceptance and response matching, all from pre-edge state
  always_comb begin
    load_req = sb.issue_valid && sb.issue_is_load && is_tracked(sb.issue_rd);
    stall    = load_req && (fifo_full || busy_q[sb.issue_rd]);
    push     = load_req && !stall;
    pop      = sb.mem_rvalid && !fifo_empty;
  end

  // busy vector and sticky error update; a same-register push and pop cannot coincide
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (pop) begin
      busy_d[head_rd] = 1'b0;
    end
    if (push) begin
      busy_d[sb.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (sb.mem_rvalid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // scoreboard state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign sb.issue_stall    = stall;
  assign sb.hazard_stall   = (is_tracked(sb.rs1) && busy_q[sb.rs1]) ||
                             (is_tracked(sb.rs2) && busy_q[sb.rs2]);
  assign sb.wb_valid       = pop;
  assign sb.wb_rd          = head_rd;
  assign sb.pending_count  = fifo_count;
  assign sb.busy           = busy_q;
  assign sb.err_unexpected = err_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// tb/tb_load_scoreboard.sv - randomized scoreboard bench for load_scoreboard
module tb_load_scoreboard;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  load_scoreboard_if #(.DEPTH(DEPTH)) sb_if ();

  load_scoreboard #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: set of pending registers plus issue-ordered list
  bit mbusy [32];
  int mq [$];
  bit merr;
  int exp_wb_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = mbusy[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    mq.delete();
    exp_wb_q.delete();
    merr = 1'b0;
  endtask

  // one clock of stimulus; checks pre-edge outputs then advances the model across the edge
  task automatic cycle(input bit v, input bit ld, input int rd, input int r1, input int r2, input bit rv);
    bit load_req, e_is, e_hz, e_wb;
    int h;
    @(negedge clk);
    sb_if.issue_valid   = v;
    sb_if.issue_is_load = ld;
    sb_if.issue_rd      = rd[4:0];
    sb_if.rs1           = r1[4:0];
    sb_if.rs2           = r2[4:0];
    sb_if.mem_rvalid    = rv;
    #2;
    load_req = v && ld && (rd != 0);
    e_is = load_req && ((mq.size() == DEPTH) || mbusy[rd]);
    e_hz = ((r1 != 0) && mbusy[r1]) || ((r2 != 0) && mbusy[r2]);
    e_wb = rv && (mq.size() != 0);
    chk("issue_stall", sb_if.issue_stall, e_is);
    chk("hazard_stall", sb_if.hazard_stall, e_hz);
    chk("wb_valid", sb_if.wb_valid, e_wb);
    chk("pending_count", sb_if.pending_count, mq.size());
    chk("busy", sb_if.busy, model_busy_vec());
    chk("err_unexpected", sb_if.err_unexpected, merr);
    if (rv) begin
      if (mq.size() != 0) begin
        h = mq.pop_front();
        mbusy[h] = 1'b0;
      end else begin
        merr = 1'b1;
      end
    end
    if (load_req && !e_is) begin
      mq.push_back(rd);
      mbusy[rd] = 1'b1;
      exp_wb_q.push_back(rd);
    end
  endtask

  // asynchronous reset asserted between edges; state must clear before any clock edge
  task automatic async_reset(input int probe_rd);
    @(posedge clk);
    #2;
    sb_if.issue_valid   = 1'b1;
    sb_if.issue_is_load = 1'b1;
    sb_if.issue_rd      = probe_rd[4:0];
    sb_if.rs1           = probe_rd[4:0];
    sb_if.rs2           = probe_rd[4:0];
    sb_if.mem_rvalid    = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_pending_count", sb_if.pending_count, 0);
    chk("rst_busy", sb_if.busy, 0);
    chk("rst_err", sb_if.err_unexpected, 0);
    chk("rst_hazard_stall", sb_if.hazard_stall, 0);
    chk("rst_issue_stall", sb_if.issue_stall, 0);
    chk("rst_wb_valid", sb_if.wb_valid, 0);
    model_clear();
    @(negedge clk);
    sb_if.issue_valid = 1'b0;
    sb_if.mem_rvalid  = 1'b0;
    #1 reset = 1'b0;
  endtask

  // monitor: every presented response must match the oldest expected destination
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && sb_if.wb_valid === 1'b1) begin
        if (exp_wb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_rd: got %0d expected no response at %0t", sb_if.wb_rd, $time);
        end else begin
          chk("wb_rd", sb_if.wb_rd, exp_wb_q.pop_front());
        end
      end
    end
  end

  initial begin
    sb_if.issue_valid   = 1'b0;
    sb_if.issue_is_load = 1'b0;
    sb_if.issue_rd      = '0;
    sb_if.rs1           = '0;
    sb_if.rs2           = '0;
    sb_if.mem_rvalid    = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state and a single load-use round trip
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 5, 0, 0, 0);
    cycle(0, 0, 0, 5, 0, 0);
    cycle(0, 0, 0, 5, 0, 1);
    cycle(0, 0, 0, 5, 0, 0);

    // fill the queue, stall on full even with a coincident response
    for (int r = 1; r <= 4; r++) cycle(1, 1, r, 0, 0, 0);
    cycle(1, 1, 6, 0, 0, 0);
    cycle(1, 1, 6, 0, 0, 1);
    cycle(1, 1, 6, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 6, 2, 0);

    // WAW stall on a busy destination, released only after its response edge
    cycle(1, 1, 7, 0, 0, 0);
    cycle(1, 1, 7, 7, 0, 0);
    cycle(1, 1, 7, 0, 7, 1);
    cycle(1, 1, 7, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // x0 loads are invisible; zero sources never stall
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 9, 9, 0, 0);

    // unexpected response sets a sticky error
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 3, 0, 0, 0);
    cycle(0, 0, 0, 3, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    async_reset(0);
    cycle(0, 0, 0, 0, 0, 0);

    // three pending, then asynchronous reset mid-run
    cycle(1, 1, 11, 0, 0, 0);
    cycle(1, 1, 12, 0, 0, 0);
    cycle(1, 1, 13, 0, 0, 0);
    async_reset(12);
    cycle(0, 0, 0, 12, 13, 0);

    // pointer wrap with concurrent issue and response
    cycle(1, 1, 20, 0, 0, 0);
    cycle(1, 1, 21, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 22 + i, 20 + i, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);

    // randomized traffic over a small register set to provoke WAW, full and hazard cases
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 9) < 4);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("drain_exp_queue", exp_wb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
